req_arbiter4: RTL and testbench
===============================

REQ_ARBITER4 -- requirements
Module: req_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum cycles a grant is held without done (timeout build only); legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request lines; bit i = requester i.
REQ-005 done  input  1  current owner releases the shared resource; sampled only in GRANT.
REQ-006 gnt  output  4  one-hot grant; all-zero when no grant.
REQ-007 gnt_id  output  2  binary index of the granted requester; 2'b00 when gnt_vld=0.
REQ-008 gnt_vld  output  1  a grant is active.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-010 The block SHALL implement the FSM states IDLE and GRANT; all outputs SHALL be registered.
REQ-011 IDLE with req!=0 at edge N: next state GRANT; gnt, gnt_id and gnt_vld SHALL be valid after edge N (one-cycle latency).
REQ-012 IDLE with req==0: stay IDLE; outputs zero.
REQ-013 Selection SHALL be round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins.
REQ-014 ptr (2 bits) SHALL load the winner's index at every grant.
REQ-015 GRANT: gnt, gnt_id and ptr SHALL hold constant; req changes (including the owner dropping req) SHALL be ignored.
REQ-016 GRANT with done=1 at edge N: next state IDLE; gnt_vld=0 and gnt=0 after edge N.
REQ-017 There SHALL be exactly one IDLE cycle between consecutive grants; re-arbitration occurs in that cycle.
REQ-018 done in IDLE SHALL be ignored.
REQ-019 gnt SHALL be one-hot or zero in every cycle; gnt_id SHALL equal the index of the set gnt bit.
REQ-020 A requester holding req continuously SHALL be granted within 4 grants of any other requester (no starvation).

Reset
REQ-021 rst=1 SHALL immediately force state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_vld=0, timeout=0, ptr=2'b11, hold counter=0, independent of clk.
REQ-022 rst asserted during GRANT SHALL drop the grant immediately; no timeout pulse SHALL be produced.
REQ-023 Arbitration after rst deasserts SHALL start with search order 0,1,2,3.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile in the hold watchdog.
REQ-025 With ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering GRANT and increment each GRANT cycle with done=0; in the GRANT cycle where the count equals HOLD_MAX-1 and done=0, the next edge SHALL move to IDLE, clear gnt and gnt_vld, and set timeout=1 for exactly one cycle.
REQ-026 With ARB_TIMEOUT_EN defined: done=1 in the same cycle as the count reaching HOLD_MAX-1 SHALL be a normal release with timeout=0.
REQ-027 Without ARB_TIMEOUT_EN: no counter SHALL exist; a grant SHALL be held until done; timeout SHALL be tied to 0; the port list SHALL be unchanged.

Verification
REQ-028 Reset, then req=4'b1111 -> grants in order gnt=0001,0010,0100,1000,0001, each ended by a one-cycle done and separated by one IDLE cycle.
REQ-029 req=4'b0100 in IDLE -> gnt=0100, gnt_id=2'b10, gnt_vld=1 one cycle later; dropping req while granted leaves the grant held until done.
REQ-030 req=0, done=1 pulses in IDLE -> all outputs remain 0.
REQ-031 rst pulsed mid-GRANT with req=4'b1000 -> gnt=0 immediately; after release, the grant resumes with gnt=1000 and timeout=0 throughout.
REQ-032 ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0001, done=0 -> gnt=0001 for 4 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant to 0001 after one IDLE cycle.
REQ-033 ARB_TIMEOUT_EN, HOLD_MAX=4, done=1 on the 4th grant cycle -> release with timeout=0; same stimulus without the macro -> grant held indefinitely, timeout=0.

Source files
------------

// File: rtl/req_arbiter4.sv
// req_arbiter4 -- four-requester round-robin arbiter for one shared resource.
// Latency: grant registered one cycle after a request is seen in IDLE; release one cycle after done.
// Backpressure: the owner keeps the grant until it pulses done (or the optional watchdog revokes it);
//               other requesters simply hold req and wait for their round-robin turn.
//
// Optional build macro: ARB_TIMEOUT_EN -- compiles in the hold watchdog (HOLD_MAX cycles max per grant).
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   req      in   4  request lines, bit i = requester i
//   done     in   1  owner releases the resource (only looked at while granted)
//   gnt      out  4  one-hot grant, zero when idle
//   gnt_id   out  2  binary index of the grant, zero when idle
//   gnt_vld  out  1  a grant is active
//   timeout  out  1  one-cycle pulse when the watchdog revokes a grant (always 0 without the macro)
module req_arbiter4 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    // Elaboration-time guard on the watchdog limit (the counter is 8 bits wide).
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("req_arbiter4: HOLD_MAX must be in 2..255");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_gnt_vld;
    logic       r_timeout;
    logic [1:0] r_ptr;

    logic [3:0] w_gnt_nxt;
    logic [1:0] w_gnt_id_nxt;
    logic       w_gnt_vld_nxt;
    logic       w_timeout_nxt;
    logic [1:0] w_ptr_nxt;

    logic       w_found;
    logic [1:0] w_win;
    logic [1:0] w_cand;
    logic       w_wdog_fire;

    //------------------------------------------------------------------
    // Round-robin pick: scan ptr+1, ptr+2, ptr+3, ptr (mod 4); the last
    // winner is checked last so every waiting requester gets a turn
    // within four grants.
    //------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'b00;
        w_cand  = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    //------------------------------------------------------------------
    // Hold watchdog. The counter sits at zero in IDLE, which is the same
    // as clearing it on entry to GRANT, and counts GRANT cycles without
    // done. It fires in the GRANT cycle where the count has reached
    // HOLD_MAX-1, so a grant lasts at most HOLD_MAX cycles. A done in
    // that same cycle wins and is treated as a normal release.
    //------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] r_hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_hold_cnt <= 8'd0;
        end else if (!done) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_wdog_fire = (r_state == S_GRANT) && !done && (r_hold_cnt == HOLD_LAST);
`else
    // No watchdog: a grant is held until done.
    assign w_wdog_fire = 1'b0;
`endif

    //------------------------------------------------------------------
    // State and output register. Reset parks ptr at 3 so the first
    // arbitration scans 0,1,2,3.
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'b00;
            r_gnt_vld <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 2'b11;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    //------------------------------------------------------------------
    // Next-state logic.
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (done || w_wdog_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Next-output logic (values loaded into the output registers).
    // While granted, req is ignored and everything holds; leaving GRANT
    // always passes through one IDLE cycle where re-arbitration happens.
    //------------------------------------------------------------------
    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_vld_nxt = r_gnt_vld;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt     = 4'b0001 << w_win;
                    w_gnt_id_nxt  = w_win;
                    w_gnt_vld_nxt = 1'b1;
                    w_ptr_nxt     = w_win;
                end else begin
                    w_gnt_nxt     = 4'b0000;
                    w_gnt_id_nxt  = 2'b00;
                    w_gnt_vld_nxt = 1'b0;
                end
            end
            S_GRANT: begin
                if (done || w_wdog_fire) begin
                    w_gnt_nxt     = 4'b0000;
                    w_gnt_id_nxt  = 2'b00;
                    w_gnt_vld_nxt = 1'b0;
                    w_timeout_nxt = w_wdog_fire;
                end
            end
            default: begin
                w_gnt_nxt     = 4'b0000;
                w_gnt_id_nxt  = 2'b00;
                w_gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_req_arbiter4.sv
// tb_req_arbiter4 -- self-checking bench for req_arbiter4 (HOLD_MAX = 4).
// Latency: expected outputs are queued when inputs are driven and compared one edge later.
// Backpressure: n/a (bench drives every cycle).
module tb_req_arbiter4;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int tagc   = 0;

    // Expected output word: {gnt[3:0], gnt_id[1:0], gnt_vld, timeout}
    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        int         tag;
    } sb_t;

    vec_t vq[$];
    sb_t  expq[$];

    req_arbiter4 #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] id,
                                      input logic v, input logic t);
        return {g, id, v, t};
    endfunction

    localparam logic [7:0] Z = 8'h00;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%b vld=%b to=%b, expected gnt=%b id=%b vld=%b to=%b",
                     nm, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Called at posedge+2: apply inputs, queue what must appear after the next edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic d, input logic [7:0] e);
        rst  = r;
        req  = rq;
        done = d;
        expq.push_back('{exp: e, tag: tagc});
        tagc++;
        @(posedge clk);
        #2;
    endtask

    task automatic add(input logic [3:0] rq, input logic d, input logic [7:0] e);
        vq.push_back('{req: rq, done: d, exp: e});
    endtask

    // Scoreboard side: compare one queued expectation per edge.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            check($sformatf("step%0d", e.tag), {gnt, gnt_id, gnt_vld, timeout}, e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, expected end before 200000");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // Vector table: round-robin over all four, idle done pulses,
        // single requester with req dropped/changed while held, partial sets.
        add(4'b1111, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        add(4'b1111, 1'b1, Z);
        add(4'b1111, 1'b0, ex(4'b0010, 2'd1, 1'b1, 1'b0));
        add(4'b1111, 1'b1, Z);
        add(4'b1111, 1'b0, ex(4'b0100, 2'd2, 1'b1, 1'b0));
        add(4'b1111, 1'b1, Z);
        add(4'b1111, 1'b0, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        add(4'b1111, 1'b1, Z);
        add(4'b1111, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        add(4'b1111, 1'b1, Z);
        add(4'b0000, 1'b1, Z);
        add(4'b0000, 1'b0, Z);
        add(4'b0000, 1'b1, Z);
        add(4'b0100, 1'b0, ex(4'b0100, 2'd2, 1'b1, 1'b0));
        add(4'b0000, 1'b0, ex(4'b0100, 2'd2, 1'b1, 1'b0));
        add(4'b1011, 1'b0, ex(4'b0100, 2'd2, 1'b1, 1'b0));
        add(4'b0000, 1'b1, Z);
        add(4'b0011, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        add(4'b0011, 1'b1, Z);
        add(4'b0011, 1'b0, ex(4'b0010, 2'd1, 1'b1, 1'b0));
        add(4'b0011, 1'b1, Z);
        add(4'b1001, 1'b0, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        add(4'b1001, 1'b1, Z);
        add(4'b1001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        add(4'b0000, 1'b1, Z);

        // Reset held across two edges, then check the reset state.
        @(posedge clk);
        @(posedge clk);
        #2;
        check("reset_state", {gnt, gnt_id, gnt_vld, timeout}, Z);

        for (int i = 0; i < vq.size(); i++) begin
            drive(1'b0, vq[i].req, vq[i].done, vq[i].exp);
        end

        // Reset in the middle of a grant: outputs drop without a clock edge,
        // no timeout pulse, and the grant comes back once reset is released.
        drive(1'b0, 4'b1000, 1'b0, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        drive(1'b0, 4'b1000, 1'b0, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        rst = 1'b1;
        #1;
        check("rst_async", {gnt, gnt_id, gnt_vld, timeout}, Z);
        drive(1'b1, 4'b1000, 1'b0, Z);
        drive(1'b0, 4'b1000, 1'b0, ex(4'b1000, 2'd3, 1'b1, 1'b0));
        drive(1'b0, 4'b1000, 1'b1, Z);

        // Move ptr off 3, then reset: the scan must restart at requester 0.
        drive(1'b0, 4'b0001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        drive(1'b0, 4'b0000, 1'b1, Z);
        drive(1'b1, 4'b0000, 1'b0, Z);
        drive(1'b0, 4'b0011, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        drive(1'b0, 4'b0000, 1'b1, Z);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: four grant cycles, one timeout cycle, then re-grant.
        for (int i = 0; i < HOLD; i++) begin
            drive(1'b0, 4'b0001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        drive(1'b0, 4'b0001, 1'b0, ex(4'b0000, 2'd0, 1'b0, 1'b1));
        drive(1'b0, 4'b0001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        // done in the 4th grant cycle: normal release, no timeout.
        for (int i = 1; i < HOLD; i++) begin
            drive(1'b0, 4'b0001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        drive(1'b0, 4'b0001, 1'b1, Z);
        drive(1'b0, 4'b0000, 1'b0, Z);
`else
        // No watchdog: the grant is held well past HOLD cycles until done.
        for (int i = 0; i < 3 * HOLD; i++) begin
            drive(1'b0, 4'b0001, 1'b0, ex(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        drive(1'b0, 4'b0001, 1'b1, Z);
        drive(1'b0, 4'b0000, 1'b0, Z);
`endif

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
